// File: rtl/paddle_array_ctrl.sv
// paddle_array_ctrl: moves NUM_PADDLES vertical paddles on a common movement
// tick. Each channel has a hold counter that doubles its step once a direction
// has been held for HOLD_TICKS ticks. Positions are clamped to the playfield,
// and the block can recentre and freeze all channels.
module paddle_array_ctrl #(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W       = 11,
    parameter int FIELD_TOP   = 0,
    parameter int FIELD_H     = 480,
    parameter int BAT_SMALL   = 48,
    parameter int BAT_LARGE   = 96,
    parameter int STEP        = 2,
    parameter int HOLD_TICKS  = 3,
    parameter int TICK_DIV    = 400000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PADDLES-1:0]       up,
    input  logic [NUM_PADDLES-1:0]       dn,
    input  logic                         bat_size,
    input  logic                         recenter,
    input  logic                         freeze,
    output logic [NUM_PADDLES*POS_W-1:0] pos,
    output logic [NUM_PADDLES-1:0]       moved
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    // Limits for each bat size, held one bit wider so compares cannot wrap.
    localparam logic [POS_W:0] YMAX_S = (POS_W+1)'(FIELD_TOP + FIELD_H - BAT_SMALL);
    localparam logic [POS_W:0] YMAX_L = (POS_W+1)'(FIELD_TOP + FIELD_H - BAT_LARGE);
    localparam logic [POS_W:0] YCEN_S = (POS_W+1)'(FIELD_TOP + (FIELD_H - BAT_SMALL) / 2);
    localparam logic [POS_W:0] YCEN_L = (POS_W+1)'(FIELD_TOP + (FIELD_H - BAT_LARGE) / 2);
    localparam logic [POS_W:0] TOP_X  = (POS_W+1)'(FIELD_TOP);
    localparam logic [POS_W:0] STEP_1 = (POS_W+1)'(STEP);
    localparam logic [POS_W:0] STEP_2 = (POS_W+1)'(2 * STEP);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_TICKS);

    logic [CNT_W-1:0]  cnt_q;
    logic              tick;
    logic [POS_W:0]    ymax;
    logic [POS_W:0]    ycen;

    logic [POS_W-1:0]  y_q      [NUM_PADDLES];
    logic [POS_W-1:0]  y_nxt    [NUM_PADDLES];
    logic [HOLD_W-1:0] hold_q   [NUM_PADDLES];
    logic [HOLD_W-1:0] hold_nxt [NUM_PADDLES];
    logic [POS_W:0]    step_w   [NUM_PADDLES];
    logic [POS_W:0]    sum_w    [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] moved_q;
    logic [NUM_PADDLES-1:0] moved_nxt;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign ymax = bat_size ? YMAX_L : YMAX_S;
    assign ycen = bat_size ? YCEN_L : YCEN_S;

    // Free-running movement tick divider; recenter and freeze do not touch it.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Per-channel next position, hold count and moved pulse.
    // Priority: recenter > clamp > freeze > tick movement.
    always_comb begin
        moved_nxt = '0;
        for (int i = 0; i < NUM_PADDLES; i++) begin
            step_w[i]   = (hold_q[i] == HOLD_SAT) ? STEP_2 : STEP_1;
            sum_w[i]    = {1'b0, y_q[i]} + step_w[i];
            y_nxt[i]    = y_q[i];
            hold_nxt[i] = hold_q[i];

            // Hold counter: cleared by recenter/freeze or a tick with up == dn.
            if (recenter || freeze) begin
                hold_nxt[i] = '0;
            end else if (tick) begin
                if (up[i] ^ dn[i]) begin
                    hold_nxt[i] = (hold_q[i] == HOLD_SAT) ? hold_q[i] : hold_q[i] + HOLD_W'(1);
                end else begin
                    hold_nxt[i] = '0;
                end
            end

            if (recenter) begin
                y_nxt[i] = ycen[POS_W-1:0];
            end else if ({1'b0, y_q[i]} > ymax) begin
                y_nxt[i] = ymax[POS_W-1:0];
            end else if (freeze) begin
                y_nxt[i] = y_q[i];
            end else if (tick && up[i] && !dn[i]) begin
                // Compare first so the subtraction can never underflow.
                if ({1'b0, y_q[i]} >= TOP_X + step_w[i]) begin
                    y_nxt[i] = y_q[i] - step_w[i][POS_W-1:0];
                end else begin
                    y_nxt[i] = TOP_X[POS_W-1:0];
                end
                moved_nxt[i] = (y_nxt[i] != y_q[i]);
            end else if (tick && dn[i] && !up[i]) begin
                if (sum_w[i] > ymax) begin
                    y_nxt[i] = ymax[POS_W-1:0];
                end else begin
                    y_nxt[i] = sum_w[i][POS_W-1:0];
                end
                moved_nxt[i] = (y_nxt[i] != y_q[i]);
            end
        end
    end

    // Channel state registers; reset centres each paddle for the current bat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PADDLES; i++) begin
                y_q[i]    <= ycen[POS_W-1:0];
                hold_q[i] <= '0;
            end
            moved_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PADDLES; i++) begin
                y_q[i]    <= y_nxt[i];
                hold_q[i] <= hold_nxt[i];
            end
            moved_q <= moved_nxt;
        end
    end

    assign moved = moved_q;

    generate
        for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_pos
            assign pos[g*POS_W +: POS_W] = y_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Bench for paddle_array_ctrl: a behavioural paddle model compared every
// cycle, plus directed scenarios with hand-computed positions.
module tb_paddle_array_ctrl;

  localparam int N     = 2;
  localparam int PW    = 11;
  localparam int TOP   = 0;
  localparam int FH    = 480;
  localparam int BS    = 48;
  localparam int BL    = 96;
  localparam int STEP  = 2;
  localparam int HOLD  = 3;
  localparam int TDIV  = 4;

  // clock / reset / DUT signals
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    up;
  logic [N-1:0]    dn;
  logic            bat_size;
  logic            recenter;
  logic            freeze;
  logic [N*PW-1:0] pos;
  logic [N-1:0]    moved;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  paddle_array_ctrl #(
    .NUM_PADDLES(N), .POS_W(PW), .FIELD_TOP(TOP), .FIELD_H(FH),
    .BAT_SMALL(BS), .BAT_LARGE(BL), .STEP(STEP), .HOLD_TICKS(HOLD),
    .TICK_DIV(TDIV)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .dn(dn), .bat_size(bat_size),
    .recenter(recenter), .freeze(freeze), .pos(pos), .moved(moved)
  );

  // behavioural model: paddle positions, held-tick counts, tick phase
  int m_y    [N];
  int m_hold [N];
  int m_mov  [N];
  int m_phase = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    int h, ymax, ycen, st, ny;
    bit is_tick;
    h    = bat_size ? BL : BS;
    ymax = TOP + FH - h;
    ycen = TOP + (FH - h) / 2;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_y[i] = ycen; m_hold[i] = 0; m_mov[i] = 0;
      end
      m_phase = 0;
      chk_en  = 1'b1;
    end else begin
      is_tick = (m_phase == TDIV - 1);
      m_phase = (m_phase + 1) % TDIV;
      for (int i = 0; i < N; i++) begin
        st = (m_hold[i] >= HOLD) ? 2 * STEP : STEP;
        m_mov[i] = 0;
        if (recenter) begin
          m_y[i] = ycen;
        end else if (m_y[i] > ymax) begin
          m_y[i] = ymax;
        end else if (!freeze && is_tick && (up[i] != dn[i])) begin
          if (up[i]) ny = (m_y[i] - st < TOP) ? TOP : m_y[i] - st;
          else       ny = (m_y[i] + st > ymax) ? ymax : m_y[i] + st;
          m_mov[i] = (ny != m_y[i]) ? 1 : 0;
          m_y[i] = ny;
        end
        if (recenter || freeze) m_hold[i] = 0;
        else if (is_tick) m_hold[i] = (up[i] != dn[i]) ? ((m_hold[i] < HOLD) ? m_hold[i] + 1 : HOLD) : 0;
      end
    end
  end

  function automatic int get_pos(int ch);
    return int'(pos[ch*PW +: PW]);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard: compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_pos%0d", i), get_pos(i), m_y[i]);
        check($sformatf("model_moved%0d", i), int'(moved[i]), m_mov[i]);
      end
    end
  end

  // driver: advance n falling edges, then settle before driving/checking
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_seq [4];
    exp_seq = '{212, 210, 206, 202};
    rst = 1'b1; up = '0; dn = '0; bat_size = 1'b0; recenter = 1'b0; freeze = 1'b0;
    cycles(3);
    check("reset_pos0", get_pos(0), 216);
    check("reset_pos1", get_pos(1), 216);
    check("reset_moved", int'(moved), 0);

    // up[0] held for 5 ticks; first tick lands 4 edges after reset falls
    rst = 1'b0; up[0] = 1'b1;
    cycles(3);
    check("no_early_tick", get_pos(0), 216);
    cycles(1);
    check("up_tick1", get_pos(0), 214);
    check("up_tick1_moved", int'(moved[0]), 1);
    for (int k = 0; k < 4; k++) begin
      cycles(4);
      check($sformatf("up_tick%0d", k + 2), get_pos(0), exp_seq[k]);
      check("pos1_idle", get_pos(1), 216);
    end

    // ch0 down to the floor of the field, ch1 up to the top
    up = 2'b10; dn = 2'b01;
    cycles(4 * 70);
    check("dn_clamp_ymax", get_pos(0), 432);
    check("up_clamp_top", get_pos(1), 0);
    check("no_moved_at_limit", int'(moved), 0);

    // both directions clear the hold counter; next up-only step is 2
    up = 2'b01; dn = 2'b01;
    cycles(8);
    check("both_no_move", get_pos(0), 432);
    dn = 2'b00;
    cycles(4);
    check("after_both_step2", get_pos(0), 430);
    cycles(12);
    check("reaccelerate", get_pos(0), 422);
    up = 2'b00;

    // reset in the middle of a hold and mid-period discards progress
    dn = 2'b01;
    cycles(2);
    rst = 1'b1;
    cycles(2);
    check("midreset_pos0", get_pos(0), 216);
    check("midreset_pos1", get_pos(1), 216);
    rst = 1'b0;
    cycles(3);
    check("midreset_no_early", get_pos(0), 216);
    cycles(1);
    check("midreset_first_step", get_pos(0), 218);
    cycles(4 * 60);
    check("dn_to_432", get_pos(0), 432);
    check("pos1_still_216", get_pos(1), 216);
    dn = 2'b00;

    // large bat pulls an out-of-range paddle back to the new limit
    bat_size = 1'b1;
    cycles(1);
    check("bat_clamp", get_pos(0), 384);
    check("bat_clamp_moved", int'(moved[0]), 0);
    check("bat_pos1", get_pos(1), 216);

    // recenter during a tick cycle with dn held and freeze high
    cycles(2);
    dn = 2'b01; freeze = 1'b1; recenter = 1'b1;
    cycles(1);
    check("recenter_pos0", get_pos(0), 192);
    check("recenter_pos1", get_pos(1), 192);
    check("recenter_moved", int'(moved), 0);
    recenter = 1'b0;
    cycles(4);
    check("frozen_pos0", get_pos(0), 192);
    freeze = 1'b0;
    cycles(4);
    check("unfreeze_step2", get_pos(0), 194);
    check("unfreeze_moved", int'(moved[0]), 1);
    cycles(4);
    check("unfreeze_step2b", get_pos(0), 196);
    dn = 2'b00;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_array_ctrl.md
PADDLE_ARRAY_CTRL -- requirements
Module: paddle_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_PADDLES, default 2, number of independent paddle channels (1..8).
REQ-002 SHALL have parameter POS_W, default 11, width of each position value.
REQ-003 SHALL have parameters FIELD_TOP, default 0, and FIELD_H, default 480, giving the vertical playfield in pixels.
REQ-004 SHALL have parameters BAT_SMALL, default 48, and BAT_LARGE, default 96, giving paddle heights in pixels; FIELD_H > BAT_LARGE is required.
REQ-005 SHALL have parameters STEP, default 2, base pixels per move, and HOLD_TICKS, default 3, the held-tick count before acceleration.
REQ-006 SHALL have parameter TICK_DIV, default 400000, clk cycles per movement tick (at least 1).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port up, input, NUM_PADDLES bits: per-channel move-up request (decrease y), already debounced.
REQ-010 SHALL have port dn, input, NUM_PADDLES bits: per-channel move-down request (increase y), already debounced.
REQ-011 SHALL have port bat_size, input, 1 bit: 0 selects BAT_SMALL and 1 selects BAT_LARGE for all channels.
REQ-012 SHALL have port recenter, input, 1 bit: synchronous command to centre all paddles.
REQ-013 SHALL have port freeze, input, 1 bit: while high, movement is inhibited.
REQ-014 SHALL have port pos, output, NUM_PADDLES*POS_W bits: channel i top-edge y in bits [i*POS_W +: POS_W], registered.
REQ-015 SHALL have port moved, output, NUM_PADDLES bits: a one-cycle pulse when channel i position changed due to movement.

Function
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 and wrap; internal tick is asserted in the cycle where count == TICK_DIV-1. With TICK_DIV=1, tick is asserted every cycle.
REQ-017 Derived values: H = the selected bat height; YMAX = FIELD_TOP+FIELD_H-H; YCEN = FIELD_TOP+(FIELD_H-H)/2, using integer floor division.
REQ-018 Per-channel hold counter SHALL saturate at HOLD_TICKS. It increments on each tick where exactly one of up/dn is high, and clears on any tick where up == dn.
REQ-019 Effective step SHALL be STEP while the hold counter < HOLD_TICKS, and 2*STEP once it equals HOLD_TICKS; the value is evaluated before the counter increments on that tick.
REQ-020 On a tick with up only, y SHALL become max(FIELD_TOP, y-step); no underflow is permitted, so the comparison is made before subtracting.
REQ-021 On a tick with dn only, y SHALL become min(YMAX, y+step); the sum is computed at POS_W+1 bits.
REQ-022 On a tick with up == dn, y SHALL be unchanged.
REQ-023 moved[i] SHALL be asserted in the cycle after a tick that changed y[i], and deasserted otherwise. Clamping and recentring never assert moved.
REQ-024 Clamp: on any cycle where y[i] > YMAX (for example after bat_size goes 0->1), y[i] SHALL become YMAX on the next edge. This overrides that channel's tick movement in that cycle.
REQ-025 recenter SHALL have the highest priority after rst: all y become YCEN, all hold counters clear, and moved goes to 0. The tick counter is unaffected.
REQ-026 freeze high SHALL hold all positions, clear all hold counters, and force moved to 0. Clamp and recenter still apply.
REQ-027 Priority order SHALL be: rst > recenter > clamp > freeze > tick movement.
REQ-028 Channels SHALL be fully independent; simultaneous moves on all channels are allowed in the same tick.

Reset
REQ-029 Under rst, each y SHALL be set to YCEN for the current bat_size, hold counters and the tick counter to 0, and moved to 0.
REQ-030 Reset asserted mid-tick or mid-hold SHALL discard all progress; the first post-reset tick occurs TICK_DIV cycles after rst deasserts.

Verification (bench parameters TICK_DIV=4, STEP=2, HOLD_TICKS=3, FIELD 0/480, bats 48/96)
REQ-031 Reset with bat_size=0 -> every pos = 216, moved = 0; the first tick occurs 4 cycles after rst falls.
REQ-032 up[0] held for 5 ticks from 216 -> pos0 goes 214, 212, 210, 206, 202; moved[0] pulses once per tick; pos1 stays 216.
REQ-033 Channel 0 at 430 with dn held -> 432 (YMAX), then stays; moved[0] stays 0 after reaching 432. Channel 1 at 1 with up held -> 0.
REQ-034 up and dn both high for 2 ticks after acceleration has started -> no move, hold counter cleared; the next up-only tick moves 2, not 4.
REQ-035 bat_size 0->1 with pos0 = 432 -> pos0 = 384 one cycle later, moved[0] = 0; pos1 = 216 is unchanged.
REQ-036 recenter asserted in a tick cycle with dn[0] held and freeze = 1 -> every pos = 192 (bat_size = 1), moved = 0; the next movement after freeze drops uses step 2.
